// File: rtl/hicore_agu.sv
// Address-generation stage: base+sext(imm), alignment check, store mask/data, 2-entry elastic buffer to the LSU.
// Latency: 1 cycle from issue accept to head of buffer. Backpressure: registered ready, low only when both entries are held.
// Flush empties the buffer and drops the op presented in the same cycle.
module hicore_agu #(
  parameter int ADDR_W   = 32,
  parameter int INFO_W   = 64,
  parameter int EXCP_W   = 16,
  parameter int LD_MIS_B = 4,
  parameter int ST_MIS_B = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_issue2agu_valid,
  output logic                i_issue2agu_ready,
  input  logic                i_issue2agu_cancel,
  input  logic                i_issue2agu_read,
  input  logic                i_issue2agu_unsigned,
  input  logic [1:0]          i_issue2agu_size,
  input  logic [ADDR_W-1:0]   i_issue2agu_base,
  input  logic [11:0]         i_issue2agu_imm,
  input  logic [ADDR_W-1:0]   i_issue2agu_sdata,
  input  logic [INFO_W-1:0]   i_issue2agu_info,
  output logic                o_agu2lsu_valid,
  input  logic                o_agu2lsu_ready,
  output logic                o_agu2lsu_cancel,
  output logic                o_agu2lsu_read,
  output logic                o_agu2lsu_unsigned,
  output logic                o_agu2lsu_word_access,
  output logic                o_agu2lsu_short_access,
  output logic                o_agu2lsu_byte_access,
  output logic [ADDR_W-1:0]   o_agu2lsu_addr,
  output logic [ADDR_W-1:0]   o_agu2lsu_wdata,
  output logic [ADDR_W/8-1:0] o_agu2lsu_wmask,
  output logic [INFO_W-1:0]   o_agu2lsu_info,
  input  logic                flush
);

  localparam int BW = ADDR_W / 8;

  typedef struct packed {
    logic              cancel;
    logic              read;
    logic              uns;
    logic              word_acc;
    logic              half_acc;
    logic              byte_acc;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wdata;
    logic [BW-1:0]     wmask;
    logic [INFO_W-1:0] info;
  } ent_t;

  logic [ADDR_W-1:0] addr_c;
  logic              is_byte, is_half, is_word, mis;
  logic [EXCP_W-1:0] excp_set;
  ent_t              ent_c;

  assign addr_c  = i_issue2agu_base + {{(ADDR_W-12){i_issue2agu_imm[11]}}, i_issue2agu_imm};
  assign is_byte = (i_issue2agu_size == 2'b00);
  assign is_half = (i_issue2agu_size == 2'b01);
  assign is_word = i_issue2agu_size[1];
  assign mis     = (is_half & addr_c[0]) | (is_word & (|addr_c[1:0]));

  always_comb begin
    excp_set           = '0;
    excp_set[LD_MIS_B] = mis & i_issue2agu_read;
    excp_set[ST_MIS_B] = mis & ~i_issue2agu_read;

    ent_c          = '0;
    ent_c.cancel   = i_issue2agu_cancel;
    ent_c.read     = i_issue2agu_read;
    ent_c.uns      = i_issue2agu_unsigned;
    ent_c.word_acc = is_word;
    ent_c.half_acc = is_half;
    ent_c.byte_acc = is_byte;
    ent_c.addr     = addr_c;
    ent_c.info     = i_issue2agu_info;
    ent_c.info[EXCP_W-1:0] = i_issue2agu_info[EXCP_W-1:0] | excp_set;

    if (is_byte)      ent_c.wdata = {BW{i_issue2agu_sdata[7:0]}};
    else if (is_half) ent_c.wdata = {(BW/2){i_issue2agu_sdata[15:0]}};
    else              ent_c.wdata = i_issue2agu_sdata;

    // Loads and misaligned accesses never enable any byte lane.
    if (i_issue2agu_read | mis) ent_c.wmask = '0;
    else if (is_byte)           ent_c.wmask = BW'(1) << addr_c[1:0];
    else if (is_half)           ent_c.wmask = BW'(3) << {addr_c[1], 1'b0};
    else                        ent_c.wmask = '1;
  end

  ent_t       mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt, cnt_nxt;
  logic       rdy_q;
  logic       push, pop;

  assign push = i_issue2agu_valid & rdy_q & ~flush;
  assign pop  = (cnt != 2'd0) & ~flush & o_agu2lsu_ready;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      rdy_q  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ent_c;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != 2'd2);
    end
  end

  // Ready comes straight from a flop so the LSU's ready never reaches issue.
  assign i_issue2agu_ready      = rdy_q;
  assign o_agu2lsu_valid        = (cnt != 2'd0) & ~flush;
  assign o_agu2lsu_cancel       = mem[rd_ptr].cancel;
  assign o_agu2lsu_read         = mem[rd_ptr].read;
  assign o_agu2lsu_unsigned     = mem[rd_ptr].uns;
  assign o_agu2lsu_word_access  = mem[rd_ptr].word_acc;
  assign o_agu2lsu_short_access = mem[rd_ptr].half_acc;
  assign o_agu2lsu_byte_access  = mem[rd_ptr].byte_acc;
  assign o_agu2lsu_addr         = mem[rd_ptr].addr;
  assign o_agu2lsu_wdata        = mem[rd_ptr].wdata;
  assign o_agu2lsu_wmask        = mem[rd_ptr].wmask;
  assign o_agu2lsu_info         = mem[rd_ptr].info;

endmodule

// File: tb/tb_hicore_agu.sv
// Bench for hicore_agu: directed vector table, hand sequences for backpressure/flush/reset, randomized traffic vs queue model.
module tb_hicore_agu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_issue2agu_valid, i_issue2agu_ready, i_issue2agu_cancel;
  logic        i_issue2agu_read, i_issue2agu_unsigned;
  logic [1:0]  i_issue2agu_size;
  logic [31:0] i_issue2agu_base, i_issue2agu_sdata;
  logic [11:0] i_issue2agu_imm;
  logic [63:0] i_issue2agu_info;
  logic        o_agu2lsu_valid, o_agu2lsu_ready, o_agu2lsu_cancel;
  logic        o_agu2lsu_read, o_agu2lsu_unsigned;
  logic        o_agu2lsu_word_access, o_agu2lsu_short_access, o_agu2lsu_byte_access;
  logic [31:0] o_agu2lsu_addr, o_agu2lsu_wdata;
  logic [3:0]  o_agu2lsu_wmask;
  logic [63:0] o_agu2lsu_info;
  logic        flush;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hicore_agu dut (
    .clk(clk), .rst_n(rst_n),
    .i_issue2agu_valid(i_issue2agu_valid), .i_issue2agu_ready(i_issue2agu_ready),
    .i_issue2agu_cancel(i_issue2agu_cancel), .i_issue2agu_read(i_issue2agu_read),
    .i_issue2agu_unsigned(i_issue2agu_unsigned), .i_issue2agu_size(i_issue2agu_size),
    .i_issue2agu_base(i_issue2agu_base), .i_issue2agu_imm(i_issue2agu_imm),
    .i_issue2agu_sdata(i_issue2agu_sdata), .i_issue2agu_info(i_issue2agu_info),
    .o_agu2lsu_valid(o_agu2lsu_valid), .o_agu2lsu_ready(o_agu2lsu_ready),
    .o_agu2lsu_cancel(o_agu2lsu_cancel), .o_agu2lsu_read(o_agu2lsu_read),
    .o_agu2lsu_unsigned(o_agu2lsu_unsigned), .o_agu2lsu_word_access(o_agu2lsu_word_access),
    .o_agu2lsu_short_access(o_agu2lsu_short_access), .o_agu2lsu_byte_access(o_agu2lsu_byte_access),
    .o_agu2lsu_addr(o_agu2lsu_addr), .o_agu2lsu_wdata(o_agu2lsu_wdata),
    .o_agu2lsu_wmask(o_agu2lsu_wmask), .o_agu2lsu_info(o_agu2lsu_info),
    .flush(flush)
  );

  typedef struct packed {
    logic        cancel, read, uns, word_acc, half_acc, byte_acc;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [63:0] info;
  } exp_t;

  typedef struct {
    logic        read, uns;
    logic [1:0]  size;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] sdata;
    logic [63:0] info;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wmask;
    logic [63:0] exp_info;
  } vec_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: effective address, alignment and lane rules computed arithmetically.
  function automatic exp_t model(input logic rd, input logic uns, input logic cancel, input logic [1:0] size,
                                 input logic [31:0] base, input logic [11:0] imm,
                                 input logic [31:0] sdata, input logic [63:0] info);
    exp_t e;
    int   nb;
    int   off;
    bit   mis;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = $signed(imm);
    e.addr = base + off;
    mis = (e.addr % nb) != 0;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sdata[8*(i % nb) +: 8];
    e.wmask = (rd || mis) ? 4'd0 : 4'(((1 << nb) - 1) << (e.addr % 4));
    e.info = info;
    if (mis) e.info[rd ? 4 : 6] = 1'b1;
    e.cancel = cancel; e.read = rd; e.uns = uns;
    e.word_acc = (nb == 4); e.half_acc = (nb == 2); e.byte_acc = (nb == 1);
    return e;
  endfunction

  function automatic exp_t dut_head();
    exp_t g;
    g = '{o_agu2lsu_cancel, o_agu2lsu_read, o_agu2lsu_unsigned, o_agu2lsu_word_access,
          o_agu2lsu_short_access, o_agu2lsu_byte_access, o_agu2lsu_addr, o_agu2lsu_wdata,
          o_agu2lsu_wmask, o_agu2lsu_info};
    return g;
  endfunction

  task automatic set_op(input logic v, input logic c, input logic rd, input logic u, input logic [1:0] sz,
                        input logic [31:0] b, input logic [11:0] im, input logic [31:0] sd, input logic [63:0] inf);
    i_issue2agu_valid = v;  i_issue2agu_cancel = c; i_issue2agu_read = rd;
    i_issue2agu_unsigned = u; i_issue2agu_size = sz; i_issue2agu_base = b;
    i_issue2agu_imm = im; i_issue2agu_sdata = sd; i_issue2agu_info = inf;
  endtask

  task automatic rand_op(input logic v);
    logic [31:0] b;
    b = $urandom;
    if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    set_op(v, 1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
           b, 12'($urandom), $urandom, {$urandom, $urandom});
  endtask

  // One clock against the model: called just after a rising edge with inputs applied.
  task automatic mcycle(input string tag);
    exp_t exp_h;
    logic exp_v, exp_r;
    bit   push, pop;
    @(negedge clk);
    exp_v = (q.size() > 0) && !flush;
    exp_r = (q.size() < 2);
    chk({tag, "_ready"}, 64'(i_issue2agu_ready), 64'(exp_r));
    chk({tag, "_valid"}, 64'(o_agu2lsu_valid), 64'(exp_v));
    if (exp_v && o_agu2lsu_valid) begin
      exp_h = q[0];
      checks++;
      if (dut_head() !== exp_h) begin
        failures++;
        $display("FAIL %s_head got addr=%h wd=%h wm=%h info=%h flags=%b exp addr=%h wd=%h wm=%h info=%h flags=%b",
                 tag, o_agu2lsu_addr, o_agu2lsu_wdata, o_agu2lsu_wmask, o_agu2lsu_info, dut_head().cancel,
                 exp_h.addr, exp_h.wdata, exp_h.wmask, exp_h.info, exp_h.cancel);
      end
    end
    pop  = exp_v && o_agu2lsu_ready;
    push = i_issue2agu_valid && exp_r && !flush;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model(i_issue2agu_read, i_issue2agu_unsigned, i_issue2agu_cancel, i_issue2agu_size,
                                  i_issue2agu_base, i_issue2agu_imm, i_issue2agu_sdata, i_issue2agu_info));
    end
    @(posedge clk); #1;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{1, 0, 2'b10, 32'h1000,     12'h004, 32'h1234_5678, 64'h0, 32'h1004,     32'h1234_5678, 4'b0000, 64'h0};
    vt[1] = '{0, 0, 2'b00, 32'h2003,     12'hFFF, 32'h0000_00AB, 64'h0, 32'h2002,     32'hABAB_ABAB, 4'b0100, 64'h0};
    vt[2] = '{1, 0, 2'b01, 32'h3001,     12'h000, 32'h0,         64'h0, 32'h3001,     32'h0,         4'b0000, 64'h10};
    vt[3] = '{0, 0, 2'b10, 32'h3002,     12'h000, 32'h0000_0055, 64'h0, 32'h3002,     32'h0000_0055, 4'b0000, 64'h40};
    vt[4] = '{0, 0, 2'b10, 32'hFFFF_FFFC,12'h008, 32'hDEAD_BEEF, 64'h0, 32'h0000_0004,32'hDEAD_BEEF, 4'b1111, 64'h0};
    vt[5] = '{0, 0, 2'b01, 32'h10,       12'h002, 32'h1234_BEEF, 64'h0, 32'h12,       32'hBEEF_BEEF, 4'b1100, 64'h0};
    vt[6] = '{0, 0, 2'b11, 32'h20,       12'h7FF, 32'h0102_0304, 64'h0, 32'h81F,      32'h0102_0304, 4'b0000, 64'h40};
    vt[7] = '{1, 0, 2'b01, 32'h5,        12'h000, 32'h0000_CAFE, 64'hABCD_0000_1234_0001, 32'h5, 32'hCAFE_CAFE, 4'b0000, 64'hABCD_0000_1234_0011};
    vt[8] = '{1, 1, 2'b00, 32'h7,        12'hFF8, 32'h0000_0011, 64'h0, 32'hFFFF_FFFF,32'h1111_1111, 4'b0000, 64'h0};

    rst_n = 1'b0; flush = 1'b0; o_agu2lsu_ready = 1'b1;
    set_op(0, 0, 0, 0, 2'b00, 32'h0, 12'h0, 32'h0, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_agu2lsu_valid), 64'd0);
    chk("rst_ready", 64'(i_issue2agu_ready), 64'd1);
    chk("rst_addr",  64'(o_agu2lsu_addr), 64'd0);
    chk("rst_info",  o_agu2lsu_info, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      set_op(1, 0, vt[i].read, vt[i].uns, vt[i].size, vt[i].base, vt[i].imm, vt[i].sdata, vt[i].info);
      @(posedge clk); #1;
      i_issue2agu_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(o_agu2lsu_valid), 64'd1);
      chk($sformatf("vec%0d_addr", i),  64'(o_agu2lsu_addr),  64'(vt[i].exp_addr));
      chk($sformatf("vec%0d_wdata", i), 64'(o_agu2lsu_wdata), 64'(vt[i].exp_wdata));
      chk($sformatf("vec%0d_wmask", i), 64'(o_agu2lsu_wmask), 64'(vt[i].exp_wmask));
      chk($sformatf("vec%0d_info", i),  o_agu2lsu_info,       vt[i].exp_info);
      chk($sformatf("vec%0d_word", i),  64'(o_agu2lsu_word_access), 64'(vt[i].size[1]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("vec_drained", 64'(o_agu2lsu_valid), 64'd0);
    @(posedge clk); #1;

    // Backpressure: three ops offered against a stalled LSU.
    o_agu2lsu_ready = 1'b0;
    set_op(1, 0, 1, 0, 2'b10, 32'hA000, 12'h0, 32'h0, 64'h1);  mcycle("bp_a");
    set_op(1, 0, 0, 0, 2'b00, 32'hB001, 12'h0, 32'h77, 64'h2); mcycle("bp_b");
    set_op(1, 0, 0, 0, 2'b01, 32'hC002, 12'h0, 32'h99, 64'h3); mcycle("bp_c_blocked");
    chk("bp_full_ready", 64'(i_issue2agu_ready), 64'd0);
    o_agu2lsu_ready = 1'b1;
    repeat (2) mcycle("bp_release");
    i_issue2agu_valid = 1'b0;
    repeat (3) mcycle("bp_drain");
    chk("bp_empty", 64'(q.size()), 64'd0);

    // Flush with both entries held and a new op offered.
    o_agu2lsu_ready = 1'b0;
    rand_op(1); mcycle("fl_fill0");
    rand_op(1); mcycle("fl_fill1");
    rand_op(1); flush = 1'b1;
    @(negedge clk);
    chk("fl_valid_low", 64'(o_agu2lsu_valid), 64'd0);
    @(posedge clk); #1;
    q.delete();
    flush = 1'b0; i_issue2agu_valid = 1'b0;
    @(negedge clk);
    chk("fl_ready_back", 64'(i_issue2agu_ready), 64'd1);
    chk("fl_empty", 64'(o_agu2lsu_valid), 64'd0);
    @(posedge clk); #1;

    // Cancelled misaligned load still carries its exception and keeps order.
    o_agu2lsu_ready = 1'b1;
    set_op(1, 1, 1, 0, 2'b10, 32'h4001, 12'h0, 32'h0, 64'h0); mcycle("cx_a");
    set_op(1, 0, 0, 0, 2'b00, 32'h4003, 12'h0, 32'h5A, 64'h0); mcycle("cx_b");
    @(negedge clk);
    chk("cx_cancel", 64'(o_agu2lsu_cancel), 64'd0);
    @(posedge clk); #1;
    i_issue2agu_valid = 1'b0;
    mcycle("cx_drain");

    // Asynchronous reset while entries are in flight.
    o_agu2lsu_ready = 1'b0;
    rand_op(1); mcycle("rs_fill0");
    rand_op(1); mcycle("rs_fill1");
    i_issue2agu_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_valid", 64'(o_agu2lsu_valid), 64'd0);
    chk("rs_ready", 64'(i_issue2agu_ready), 64'd1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      rand_op(1'($urandom_range(0, 2) != 0));
      o_agu2lsu_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      mcycle("rnd");
    end
    flush = 1'b0; i_issue2agu_valid = 1'b0; o_agu2lsu_ready = 1'b1;
    repeat (3) mcycle("rnd_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
